button_conditioner: RTL

//  Front end for the board command path: synchronises, debounces and edge-detects the raw push buttons.

---
 rtl/btn_pkg.sv | 27 ++
 rtl/button_conditioner_if.sv | 32 +++
 rtl/button_debounce_ch.sv | 154 +++++++++++++++
 rtl/button_conditioner.sv | 89 ++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_pkg
//  Purpose  : Shared constants for the button conditioner: per-channel FSM
//             state encoding, debounce defaults for board and simulation
//             builds, and a helper for the long-press default.
//  Revision : 1.0  initial release
// ============================================================================
package btn_pkg;

    // Per-channel debounce FSM states (2-bit encoding)
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CHK_PRESS = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_CHK_REL   = 2'd3;

    // 10 ms at 50 MHz on the board; a short window keeps simulation fast
    localparam int DEBOUNCE_CYC_BOARD = 500000;
    localparam int DEBOUNCE_CYC_SIM   = 4;

    // Largest value a cnt_w-bit counter can hold; default long-press length
    function automatic int long_cyc_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner_if
//  Purpose  : Bundle of the button conditioner's data/handshake signals.
//             master = board/command side driving raw inputs and acks,
//             slave  = the conditioner itself.
//  Revision : 1.0  initial release
// ============================================================================
interface button_conditioner_if #(
    parameter int NUM_BTN = 3,
    parameter int SW_W    = 8
);
    logic [NUM_BTN-1:0] btn_in;
    logic [SW_W-1:0]    switch_in;
    logic [NUM_BTN-1:0] pend_ack;
    logic [NUM_BTN-1:0] press_pulse;
    logic [NUM_BTN-1:0] press_pending;
    logic [NUM_BTN-1:0] btn_level;
    logic [SW_W-1:0]    switch_snap;
    logic [NUM_BTN-1:0] long_pulse;

    modport master (
        output btn_in, switch_in, pend_ack,
        input  press_pulse, press_pending, btn_level, switch_snap, long_pulse
    );

    modport slave (
        input  btn_in, switch_in, pend_ack,
        output press_pulse, press_pending, btn_level, switch_snap, long_pulse
    );
endinterface
`default_nettype wire

// File: rtl/button_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce_ch
//  Purpose  : One button channel: synchroniser, IDLE/CHK_PRESS/HELD/CHK_REL
//             debounce FSM, registered press pulse and debounced level.
//             Optional long-press detection under `LONGPRESS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module button_debounce_ch
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 20,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_BOARD,
    parameter int LONG_CYC     = long_cyc_max(CNT_W)
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic btn_i,
    output logic      accept_o,
    output logic      press_pulse_o,
    output logic      level_o,
    output logic      long_pulse_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    // Hard ceiling for the debounce count so it can never wrap
    localparam int               CAP_I   = (LONG_CYC > DEBOUNCE_CYC - 1) ? LONG_CYC : DEBOUNCE_CYC - 1;
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(CAP_I);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   level_q, level_d;

`ifdef LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_CYC - 1);
    logic long_q, long_d;
    logic done_q, done_d;
`endif

    assign synced = sync_q[SYNC_STAGES-1];

    // Next-state logic for the debounce FSM and its shared counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
`ifdef LONGPRESS_EN
        long_d  = 1'b0;
        done_d  = done_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (synced) begin
                    state_d = ST_CHK_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_CHK_PRESS: begin
                if (!synced) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                end else if (cnt_q != CNT_CAP) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!synced) begin
                    state_d = ST_CHK_REL;
                    cnt_d   = '0;
                end
`ifdef LONGPRESS_EN
                else if (cnt_q != LONG_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                    // Fire once per hold; a release bounce must not re-arm it
                    if (cnt_q == LONG_M1 && !done_q) begin
                        long_d = 1'b1;
                        done_d = 1'b1;
                    end
                end
`endif
            end
            ST_CHK_REL: begin
                if (synced) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef LONGPRESS_EN
                    done_d  = 1'b0;
`endif
                end else if (cnt_q != CNT_CAP) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Synchroniser chain, FSM state, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

`ifdef LONGPRESS_EN
    // Long-press pulse and once-per-hold guard
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            long_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            long_q <= long_d;
            done_q <= done_d;
        end
    end
    assign long_pulse_o = long_q;
`else
    assign long_pulse_o = 1'b0;
`endif

    // accept_o marks the edge that raises press_pulse_o (used for the snapshot)
    assign accept_o      = pulse_d;
    assign press_pulse_o = pulse_q;
    assign level_o       = level_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Synchronises, debounces and edge-detects the push buttons;
//             provides sticky pending flags with ack and a switch snapshot
//             taken on each button-0 press. Everything runs on clk.
//  Options  : `LONGPRESS_EN enables long-press pulses (long_pulse).
//  Revision : 1.0  initial release
// ============================================================================
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN      = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 20,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_BOARD,
    parameter int LONG_CYC     = long_cyc_max(CNT_W),
    parameter int SW_W         = 8
) (
    input  wire logic            clk,
    input  wire logic            reset,
    button_conditioner_if.slave  bus
);

    logic [NUM_BTN-1:0] accept_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] long_w;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [SW_W-1:0]    sw_sync_q [SYNC_STAGES];
    logic [SW_W-1:0]    snap_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_debounce_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .CNT_W        (CNT_W),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .btn_i         (bus.btn_in[i]),
            .accept_o      (accept_w[i]),
            .press_pulse_o (press_w[i]),
            .level_o       (level_w[i]),
            .long_pulse_o  (long_w[i])
        );
    end

    // Pending: a visible press pulse sets the flag and wins over a same-cycle ack
    always_comb begin
        pend_d = (pend_q & ~bus.pend_ack) | press_w;
    end

    // Pending flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Switch synchroniser; snapshot taken on the edge that raises press_pulse[0]
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sw_sync_q[k] <= '0;
            end
            snap_q <= '0;
        end else begin
            sw_sync_q[0] <= bus.switch_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sw_sync_q[k] <= sw_sync_q[k-1];
            end
            if (accept_w[0]) begin
                snap_q <= sw_sync_q[SYNC_STAGES-1];
            end
        end
    end

    assign bus.press_pulse   = press_w;
    assign bus.press_pending = pend_q;
    assign bus.btn_level     = level_w;
    assign bus.long_pulse    = long_w;
    assign bus.switch_snap   = snap_q;

endmodule
`default_nettype wire
